// File: rtl/vend_dispense_ctrl_if.sv
// ---------------------------------------------------------------------------
// vend_dispense_ctrl_if
//   Signal bundle between the vending controller environment and the
//   dispense controller.
//
//   y            [1:0]  dispense code (01 CocaCola, 10 Pepsi, 00 none)
//   c            [1:0]  change code   (01 Rs 5,  10 Rs 10, 00 none)
//   drop_sense          bottle-drop sensor, synchronous to clk
//   fault_clr           clears sticky fault / overrun flags
//   coke_motor          CocaCola motor drive
//   pepsi_motor         Pepsi motor drive
//   coin5_eject         Rs 5 ejector drive
//   coin10_eject        Rs 10 ejector drive
//   busy                transaction executing or buffered
//   vend_done           one-cycle completion pulse
//   fault               sticky drop-timeout flag
//   overrun             sticky dropped/illegal-event flag
//
//   master : upstream/environment side (drives codes and sensor)
//   slave  : dispense controller side (drives actuators and status)
// ---------------------------------------------------------------------------
interface vend_dispense_ctrl_if;
    logic [1:0] y;
    logic [1:0] c;
    logic       drop_sense;
    logic       fault_clr;
    logic       coke_motor;
    logic       pepsi_motor;
    logic       coin5_eject;
    logic       coin10_eject;
    logic       busy;
    logic       vend_done;
    logic       fault;
    logic       overrun;

    modport master (
        output y, c, drop_sense, fault_clr,
        input  coke_motor, pepsi_motor, coin5_eject, coin10_eject,
               busy, vend_done, fault, overrun
    );

    modport slave (
        input  y, c, drop_sense, fault_clr,
        output coke_motor, pepsi_motor, coin5_eject, coin10_eject,
               busy, vend_done, fault, overrun
    );
endinterface

// File: rtl/vend_dispense_ctrl.sv
// ---------------------------------------------------------------------------
// vend_dispense_ctrl
//   Turns one-cycle dispense/change codes from the drink-selection FSM into
//   timed actuator pulses: motor phase, drop confirmation with timeout,
//   coin-eject phase and an inter-transaction gap. A one-deep buffer absorbs
//   a transaction that arrives while another is executing.
//
//   clk    rising-edge system clock
//   reset  asynchronous active-low reset (0 = reset)
//   bus    vend_dispense_ctrl_if.slave (codes, sensor, actuators, status)
// ---------------------------------------------------------------------------
module vend_dispense_ctrl #(
    parameter int MOTOR_CYCLES = 8,
    parameter int DROP_TIMEOUT = 32,
    parameter int COIN_CYCLES  = 4,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    vend_dispense_ctrl_if.slave  bus
);

    // One shared phase counter, wide enough for the longest phase.
    localparam int MAX_AB = (MOTOR_CYCLES > DROP_TIMEOUT) ? MOTOR_CYCLES : DROP_TIMEOUT;
    localparam int MAX_CD = (COIN_CYCLES > GAP_CYCLES) ? COIN_CYCLES : GAP_CYCLES;
    localparam int MAXP   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = (MAXP > 1) ? $clog2(MAXP) : 1;

    typedef enum logic [2:0] {IDLE, VEND, WAIT_DROP, CHANGE, GAP} state_t;

    typedef struct packed {
        logic [1:0] y;
        logic [1:0] c;
    } txn_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    txn_t          txn, txn_d;
    txn_t          buf_q, buf_d;
    logic          buf_full, buf_full_d;
    logic          drop_seen, drop_seen_d;

    logic coke_q, pepsi_q, coin5_q, coin10_q;
    logic busy_q, done_q, fault_q, overrun_q;
    logic done_d, fault_set, ovr_set, pop;

    logic ev, illegal;

    assign ev      = (bus.y != 2'b00) || (bus.c != 2'b00);
    assign illegal = (bus.y == 2'b11) || (bus.c == 2'b11);

    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state;
        cnt_d       = (cnt == '1) ? cnt : cnt + CW'(1);  // saturating
        txn_d       = txn;
        buf_d       = buf_q;
        buf_full_d  = buf_full;
        drop_seen_d = drop_seen;
        done_d      = 1'b0;
        fault_set   = 1'b0;
        ovr_set     = 1'b0;
        pop         = 1'b0;

        case (state)
            IDLE: begin
                if (buf_full) begin
                    pop         = 1'b1;
                    txn_d       = buf_q;
                    cnt_d       = '0;
                    drop_seen_d = 1'b0;
                    // The buffer only ever holds a non-empty event.
                    state_d     = (buf_q.y != 2'b00) ? VEND : CHANGE;
                end
            end
            VEND: begin
                if (bus.drop_sense)
                    drop_seen_d = 1'b1;
                if (cnt == CW'(MOTOR_CYCLES - 1)) begin
                    state_d = WAIT_DROP;
                    cnt_d   = '0;
                end
            end
            WAIT_DROP: begin
                if (drop_seen || bus.drop_sense || cnt == CW'(DROP_TIMEOUT - 1)) begin
                    // A drop on the final wait edge still counts as a drop.
                    fault_set = !(drop_seen || bus.drop_sense);
                    state_d   = (txn.c != 2'b00) ? CHANGE : GAP;
                    cnt_d     = '0;
                end
            end
            CHANGE: begin
                if (cnt == CW'(COIN_CYCLES - 1)) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end
            end
            GAP: begin
                if (cnt == CW'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Buffer: a pop frees the slot on the same edge a new event may take it.
        if (pop)
            buf_full_d = 1'b0;
        if (ev) begin
            if (illegal) begin
                ovr_set = 1'b1;
            end else if (!buf_full || pop) begin
                buf_d      = '{y: bus.y, c: bus.c};
                buf_full_d = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            txn       <= '0;
            buf_q     <= '0;
            buf_full  <= 1'b0;
            drop_seen <= 1'b0;
            coke_q    <= 1'b0;
            pepsi_q   <= 1'b0;
            coin5_q   <= 1'b0;
            coin10_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fault_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            txn       <= txn_d;
            buf_q     <= buf_d;
            buf_full  <= buf_full_d;
            drop_seen <= drop_seen_d;
            // Actuators are decoded from the next state, so they are
            // registered and mutually exclusive by construction.
            coke_q    <= (state_d == VEND)   && (txn_d.y == 2'b01);
            pepsi_q   <= (state_d == VEND)   && (txn_d.y == 2'b10);
            coin5_q   <= (state_d == CHANGE) && (txn_d.c == 2'b01);
            coin10_q  <= (state_d == CHANGE) && (txn_d.c == 2'b10);
            busy_q    <= (state_d != IDLE) || buf_full_d;
            done_q    <= done_d;
            // Set has priority over clear.
            fault_q   <= fault_set | (fault_q   & ~bus.fault_clr);
            overrun_q <= ovr_set   | (overrun_q & ~bus.fault_clr);
        end
    end

    assign bus.coke_motor   = coke_q;
    assign bus.pepsi_motor  = pepsi_q;
    assign bus.coin5_eject  = coin5_q;
    assign bus.coin10_eject = coin10_q;
    assign bus.busy         = busy_q;
    assign bus.vend_done    = done_q;
    assign bus.fault        = fault_q;
    assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vend_dispense_ctrl
//   Directed bench for vend_dispense_ctrl. Inputs are driven and outputs are
//   sampled 1 time unit after each rising edge. Edge N is the edge on which
//   an event is presented; expected values are counted from there.
// ---------------------------------------------------------------------------
module tb_vend_dispense_ctrl;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   hits;

    vend_dispense_ctrl_if bus_if ();

    vend_dispense_ctrl #(
        .MOTOR_CYCLES (8),
        .DROP_TIMEOUT (32),
        .COIN_CYCLES  (4),
        .GAP_CYCLES   (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Steps n edges and counts how many of them leave the selected output high.
    task automatic count_high(input int sel, input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            step();
            case (sel)
                0: if (bus_if.coke_motor   === 1'b1) cnt++;
                1: if (bus_if.pepsi_motor  === 1'b1) cnt++;
                2: if (bus_if.coin5_eject  === 1'b1) cnt++;
                default: if (bus_if.coin10_eject === 1'b1) cnt++;
            endcase
        end
    endtask

    initial begin
        reset             = 1'b0;
        bus_if.y          = 2'b00;
        bus_if.c          = 2'b00;
        bus_if.drop_sense = 1'b0;
        bus_if.fault_clr  = 1'b0;

        // ---------------- reset state ----------------
        step(3);
        chk("rst_outputs", {bus_if.coke_motor, bus_if.pepsi_motor, bus_if.coin5_eject,
            bus_if.coin10_eject, bus_if.busy, bus_if.vend_done, bus_if.fault,
            bus_if.overrun}, 0);
        reset = 1'b1;
        step(2);
        chk("idle_busy", bus_if.busy, 0);

        // ---------------- T1: CocaCola, no change, late drop ----------------
        bus_if.y = 2'b01;
        step();                                   // edge N: captured
        bus_if.y = 2'b00;
        chk("t1_busy_capture", bus_if.busy, 1);
        chk("t1_coke_not_yet", bus_if.coke_motor, 0);
        count_high(0, 8, hits);                   // edges N+1..N+8
        chk("t1_coke_cycles", hits, 8);
        step();                                   // N+9: WAIT_DROP
        chk("t1_coke_off", bus_if.coke_motor, 0);
        step(2);                                  // N+11
        bus_if.drop_sense = 1'b1;
        step();                                   // N+12: drop detected -> GAP
        bus_if.drop_sense = 1'b0;
        chk("t1_no_coin", {bus_if.coin5_eject, bus_if.coin10_eject}, 0);
        chk("t1_done_early", bus_if.vend_done, 0);
        step();                                   // N+13
        chk("t1_done_gap", bus_if.vend_done, 0);
        step();                                   // N+14
        chk("t1_done", bus_if.vend_done, 1);
        chk("t1_busy_end", bus_if.busy, 0);
        step();
        chk("t1_done_pulse", bus_if.vend_done, 0);
        chk("t1_fault", bus_if.fault, 0);

        // ---------------- T2: Pepsi + Rs 5, drop during motor ----------------
        bus_if.y = 2'b10;
        bus_if.c = 2'b01;
        step();                                   // N
        bus_if.y = 2'b00;
        bus_if.c = 2'b00;
        step();                                   // N+1
        chk("t2_pepsi_on", bus_if.pepsi_motor, 1);
        chk("t2_coke_off", bus_if.coke_motor, 0);
        step();                                   // N+2
        bus_if.drop_sense = 1'b1;
        step();                                   // N+3: drop latched in VEND
        bus_if.drop_sense = 1'b0;
        count_high(1, 5, hits);                   // N+4..N+8
        chk("t2_pepsi_tail", hits, 5);
        step();                                   // N+9: WAIT_DROP
        chk("t2_pepsi_off", bus_if.pepsi_motor, 0);
        count_high(2, 4, hits);                   // N+10..N+13
        chk("t2_coin5_cycles", hits, 4);
        step();                                   // N+14: GAP
        chk("t2_coin5_off", bus_if.coin5_eject, 0);
        chk("t2_no_coin10", bus_if.coin10_eject, 0);
        step(2);                                  // N+16
        chk("t2_done", bus_if.vend_done, 1);
        chk("t2_fault", bus_if.fault, 0);

        // ---------------- T3: cancel refund Rs 10 ----------------
        step();
        bus_if.c = 2'b10;
        step();                                   // N
        bus_if.c = 2'b00;
        count_high(3, 4, hits);                   // N+1..N+4
        chk("t3_coin10_cycles", hits, 4);
        chk("t3_no_motor", {bus_if.coke_motor, bus_if.pepsi_motor}, 0);
        step();                                   // N+5
        chk("t3_coin10_off", bus_if.coin10_eject, 0);
        step();                                   // N+6
        chk("t3_done_gap", bus_if.vend_done, 0);
        step();                                   // N+7
        chk("t3_done", bus_if.vend_done, 1);

        // ---------------- T4: drop timeout ----------------
        step();
        bus_if.y = 2'b01;
        step();                                   // N
        bus_if.y = 2'b00;
        count_high(0, 8, hits);                   // N+1..N+8
        chk("t4_coke_cycles", hits, 8);
        step();                                   // N+9: WAIT_DROP entered
        step(31);                                 // N+40
        chk("t4_fault_before", bus_if.fault, 0);
        step();                                   // N+41: timeout
        chk("t4_fault_set", bus_if.fault, 1);
        chk("t4_busy_gap", bus_if.busy, 1);
        step(2);                                  // N+43
        chk("t4_done", bus_if.vend_done, 1);
        bus_if.fault_clr = 1'b1;
        step();
        bus_if.fault_clr = 1'b0;
        chk("t4_fault_clr", bus_if.fault, 0);

        // ---------------- T5: three back-to-back events ----------------
        bus_if.y = 2'b01;
        step();                                   // E: captured
        bus_if.y = 2'b10;
        step();                                   // E+1: pop coke, capture pepsi
        chk("t5_first_runs", bus_if.coke_motor, 1);
        bus_if.y = 2'b01;
        bus_if.c = 2'b10;
        step();                                   // E+2: buffer full -> dropped
        bus_if.y = 2'b00;
        bus_if.c = 2'b00;
        chk("t5_overrun", bus_if.overrun, 1);
        chk("t5_coke_still", bus_if.coke_motor, 1);
        step(2);                                  // E+4
        bus_if.drop_sense = 1'b1;
        step();                                   // E+5
        bus_if.drop_sense = 1'b0;
        step(4);                                  // E+9
        chk("t5_coke_off", bus_if.coke_motor, 0);
        step(3);                                  // E+12
        chk("t5_done1", bus_if.vend_done, 1);
        chk("t5_busy_buffered", bus_if.busy, 1);
        chk("t5_pepsi_wait", bus_if.pepsi_motor, 0);
        step();                                   // E+13: buffered pepsi starts
        chk("t5_pepsi_on", bus_if.pepsi_motor, 1);
        bus_if.drop_sense = 1'b1;
        count_high(1, 7, hits);                   // E+14..E+20
        bus_if.drop_sense = 1'b0;
        chk("t5_pepsi_cycles", hits, 7);
        step();                                   // E+21
        chk("t5_no_coin", {bus_if.pepsi_motor, bus_if.coin10_eject}, 0);
        step(3);                                  // E+24
        chk("t5_done2", bus_if.vend_done, 1);
        chk("t5_busy_end", bus_if.busy, 0);
        step();
        chk("t5_third_dropped", {bus_if.coke_motor, bus_if.coin10_eject, bus_if.busy}, 0);

        // ---------------- illegal code and clear priority ----------------
        bus_if.fault_clr = 1'b1;
        step();
        bus_if.fault_clr = 1'b0;
        chk("ovr_clr", bus_if.overrun, 0);
        bus_if.y = 2'b11;
        step();
        bus_if.y = 2'b00;
        chk("illegal_ovr", bus_if.overrun, 1);
        chk("illegal_busy", bus_if.busy, 0);
        step();
        chk("illegal_no_act", {bus_if.coke_motor, bus_if.pepsi_motor, bus_if.busy}, 0);
        bus_if.fault_clr = 1'b1;
        bus_if.c = 2'b11;
        step();                                   // set and clear on same edge
        bus_if.c = 2'b00;
        chk("set_wins", bus_if.overrun, 1);
        step();                                   // clear alone
        bus_if.fault_clr = 1'b0;
        chk("clr_after", bus_if.overrun, 0);

        // ---------------- T6: async reset mid-VEND ----------------
        bus_if.y = 2'b01;
        step();                                   // N: coke captured
        bus_if.y = 2'b10;
        step();                                   // N+1: pop coke, buffer pepsi
        bus_if.y = 2'b00;
        step(2);                                  // N+3
        chk("t6_coke_on", bus_if.coke_motor, 1);
        #2 reset = 1'b0;
        #1;                                       // well before the next edge
        chk("t6_async_off", bus_if.coke_motor, 0);
        chk("t6_busy_rst", bus_if.busy, 0);
        step(2);
        reset = 1'b1;
        step(3);
        chk("t6_after_release", {bus_if.coke_motor, bus_if.pepsi_motor, bus_if.coin5_eject,
            bus_if.coin10_eject, bus_if.busy, bus_if.vend_done}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
